// File: rtl/bit_insertion_4x8_seq.sv
// Rebuilds 8-bit words from 4-bit fragments written at a commanded bit offset.
// The assembled word leaves as a registered one-cycle pulse on completion.
//
// state | meaning
// IDLE  | accumulator empty (acc, mask and overlap all zero)
// ACCUM | at least one fragment of the current word is held
module bit_insertion_4x8_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [IN_DATA_WIDTH-1:0] i_data_bus,
  input  logic                     i_en,
  input  logic [COMMAND_WIDTH-1:0] i_cmd,
  input  logic                     i_last,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_data_bus,
  output logic [DATA_WIDTH-1:0]    o_mask,
  output logic                     o_overlap
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   acc_mask_q, acc_mask_d;
  logic                    ovl_q, ovl_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic                    overlap_q, overlap_d;

  logic                    accept;
  logic [2:0]              offset;
  logic [DATA_WIDTH-1:0]   new_mask;
  logic [DATA_WIDTH-1:0]   new_data;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   merged_mask;
  logic                    new_overlap;
  logic                    complete;

  assign accept = i_en & i_valid;

  // Same offset encoding the selector uses: cmd[2]=0 means offset 0 regardless of cmd[1:0].
  always_comb begin
    offset = 3'd0;
    if (i_cmd[2]) offset = 3'd1 + {1'b0, i_cmd[1:0]};
  end

  always_comb begin
    new_mask    = 8'h0F << offset;
    new_data    = {4'b0000, i_data_bus} << offset;
    merged_word = (acc_q & ~new_mask) | new_data;
    merged_mask = acc_mask_q | new_mask;
    new_overlap = |(acc_mask_q & new_mask);
    complete    = i_last | (merged_mask == 8'hFF);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_mask_d = acc_mask_q;
    ovl_d      = ovl_q;
    valid_d    = 1'b0;
    data_d     = '0;
    mask_d     = '0;
    overlap_d  = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (complete) begin
            state_d    = IDLE;
            acc_d      = '0;
            acc_mask_d = '0;
            ovl_d      = 1'b0;
            valid_d    = 1'b1;
            data_d     = merged_word;
            mask_d     = merged_mask;
            overlap_d  = ovl_q | new_overlap;
          end else begin
            state_d    = ACCUM;
            acc_d      = merged_word;
            acc_mask_d = merged_mask;
            ovl_d      = ovl_q | new_overlap;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        acc_d      = '0;
        acc_mask_d = '0;
        ovl_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_mask_q <= '0;
      ovl_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      mask_q     <= '0;
      overlap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_mask_q <= acc_mask_d;
      ovl_q      <= ovl_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      overlap_q  <= overlap_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
  assign o_mask     = mask_q;
  assign o_overlap  = overlap_q;

endmodule

// File: tb/tb_bit_insertion_4x8_seq.sv
// Directed vector bench for bit_insertion_4x8_seq: a table of per-cycle
// stimulus/expectation records plus hand-written async-reset sequences.
module tb_bit_insertion_4x8_seq;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic [3:0] i_data_bus;
  logic       i_en;
  logic [2:0] i_cmd;
  logic       i_last;
  logic       o_valid;
  logic [7:0] o_data_bus;
  logic [7:0] o_mask;
  logic       o_overlap;

  int errors = 0;
  int checks = 0;

  bit_insertion_4x8_seq dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_mask     (o_mask),
    .o_overlap  (o_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [2:0] cmd;
    logic [3:0] data;
    logic       last;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_mask;
    logic       exp_ovl;
  } vec_t;

  vec_t vecs[18];

  task automatic check_outputs(input string name, input logic ev, input logic [7:0] ed,
                               input logic [7:0] em, input logic eo);
    checks++;
    if (o_valid !== ev || o_data_bus !== ed || o_mask !== em || o_overlap !== eo) begin
      errors++;
      $display("FAIL %s: got valid=%0b data=%02h mask=%02h ovl=%0b, want valid=%0b data=%02h mask=%02h ovl=%0b",
               name, o_valid, o_data_bus, o_mask, o_overlap, ev, ed, em, eo);
    end
  endtask

  task automatic drive(input logic en, input logic valid, input logic [2:0] cmd,
                       input logic [3:0] data, input logic last);
    i_en       = en;
    i_valid    = valid;
    i_cmd      = cmd;
    i_data_bus = data;
    i_last     = last;
  endtask

  initial begin
    //            en  vl  cmd     data  last  ev  data   mask   ovl
    vecs[0]  = '{1'b1,1'b1,3'b000,4'hA,1'b0, 1'b0,8'h00,8'h00,1'b0};
    vecs[1]  = '{1'b1,1'b1,3'b111,4'h5,1'b1, 1'b1,8'h5A,8'hFF,1'b0};
    vecs[2]  = '{1'b0,1'b0,3'b000,4'h0,1'b0, 1'b0,8'h00,8'h00,1'b0};
    vecs[3]  = '{1'b1,1'b1,3'b101,4'hF,1'b1, 1'b1,8'h3C,8'h3C,1'b0};
    vecs[4]  = '{1'b1,1'b1,3'b000,4'hF,1'b0, 1'b0,8'h00,8'h00,1'b0};
    vecs[5]  = '{1'b1,1'b1,3'b100,4'h0,1'b1, 1'b1,8'h01,8'h1F,1'b1};
    vecs[6]  = '{1'b1,1'b1,3'b000,4'h3,1'b0, 1'b0,8'h00,8'h00,1'b0};
    vecs[7]  = '{1'b1,1'b1,3'b111,4'hC,1'b0, 1'b1,8'hC3,8'hFF,1'b0};
    vecs[8]  = '{1'b1,1'b1,3'b000,4'h9,1'b1, 1'b1,8'h09,8'h0F,1'b0};
    vecs[9]  = '{1'b1,1'b1,3'b000,4'h9,1'b0, 1'b0,8'h00,8'h00,1'b0};
    vecs[10] = '{1'b0,1'b1,3'b000,4'h0,1'b1, 1'b0,8'h00,8'h00,1'b0};
    vecs[11] = '{1'b0,1'b1,3'b000,4'h0,1'b1, 1'b0,8'h00,8'h00,1'b0};
    vecs[12] = '{1'b0,1'b1,3'b000,4'h0,1'b1, 1'b0,8'h00,8'h00,1'b0};
    vecs[13] = '{1'b1,1'b1,3'b111,4'h6,1'b1, 1'b1,8'h69,8'hFF,1'b0};
    vecs[14] = '{1'b1,1'b0,3'b000,4'h7,1'b1, 1'b0,8'h00,8'h00,1'b0};
    vecs[15] = '{1'b1,1'b1,3'b011,4'h5,1'b1, 1'b1,8'h05,8'h0F,1'b0};
    vecs[16] = '{1'b1,1'b1,3'b110,4'hF,1'b1, 1'b1,8'h78,8'h78,1'b0};
    vecs[17] = '{1'b0,1'b0,3'b000,4'h0,1'b0, 1'b0,8'h00,8'h00,1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
    #1;
    check_outputs("reset_state", 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].cmd, vecs[i].data, vecs[i].last);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_mask, vecs[i].exp_ovl);
    end

    // Reset asserted while a word is being presented must clear outputs before the next edge.
    drive(1'b1, 1'b1, 3'b101, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("pre_reset_pulse", 1'b1, 8'h3C, 8'h3C, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_outputs("async_reset_immediate", 1'b0, 8'h00, 8'h00, 1'b0);
    #1 rst = 1'b0;

    // Partial word discarded by reset.
    drive(1'b1, 1'b1, 3'b000, 4'hE, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("partial_E", 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_outputs("reset_mid_word", 1'b0, 8'h00, 8'h00, 1'b0);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 3'b111, 4'h7, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("after_reset_word", 1'b1, 8'h70, 8'hF0, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_reset_quiet%0d", k), 1'b0, 8'h00, 8'h00, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
